// File: rtl/poly_pkg.sv
// poly_pkg: shared constants, types and helpers for the polynomial add/sub datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default geometry (Q=17, N=8, LOGQ=5, LOGN=3, LANES=2), coeff_t,
//           MODE_ADD/MODE_SUB encodings and beats_per_poly() helper.
package poly_pkg;

  localparam int unsigned Q_DEF     = 17;
  localparam int unsigned N_DEF     = 8;
  localparam int unsigned LOGQ_DEF  = 5;
  localparam int unsigned LOGN_DEF  = 3;
  localparam int unsigned LANES_DEF = 2;

  // Beats needed to carry one N-coefficient polynomial.
  localparam int unsigned BEATS_PER_POLY_DEF = N_DEF / LANES_DEF;

  typedef logic [LOGQ_DEF-1:0] coeff_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned beats_per_poly(input int unsigned n, input int unsigned lanes);
    return n / lanes;
  endfunction

endpackage

// File: rtl/poly_mod_lane.sv
// poly_mod_lane: one lane of modular add/subtract over Z_Q, purely combinational.
// Latency: 0 (the top registers o_raw into stage 1 and o_res into stage 2).
// Backpressure: none here; pipeline control lives in the top.
// Ports: i_a/i_b/i_sub -> o_raw        (stage-1 partial result, LOGQ+1 bits)
//        i_raw/i_mode  -> o_res        (stage-2 reduced result, LOGQ bits)
module poly_mod_lane
  import poly_pkg::*;
#(
  parameter int unsigned Q    = 17,
  parameter int unsigned LOGQ = 5
) (
  input  logic [LOGQ-1:0] i_a,
  input  logic [LOGQ-1:0] i_b,
  input  logic            i_sub,
  output logic [LOGQ:0]   o_raw,
  input  logic [LOGQ:0]   i_raw,
  input  logic            i_mode,
  output logic [LOGQ-1:0] o_res
);

  localparam logic [LOGQ:0] QW = (LOGQ+1)'(Q);

  logic [LOGQ:0] w_a;
  logic [LOGQ:0] w_b;
  logic [LOGQ:0] w_red;

  assign w_a = {1'b0, i_a};
  assign w_b = {1'b0, i_b};

  // Subtraction folds the borrow back in at stage 1, so stage 2 only has to
  // reduce the add path. a+Q-b cannot overflow LOGQ+1 bits because a,Q < 2**LOGQ.
  always_comb begin
    o_raw = w_a + w_b;
    if (i_sub == MODE_SUB) begin
      o_raw = (w_a < w_b) ? (w_a + QW - w_b) : (w_a - w_b);
    end
  end

  always_comb begin
    w_red = i_raw;
    if ((i_mode == MODE_ADD) && (i_raw >= QW)) begin
      w_red = i_raw - QW;
    end
  end

  assign o_res = w_red[LOGQ-1:0];

endmodule

// File: rtl/poly_vec_addsub.sv
// poly_vec_addsub: LANES-wide modular add/sub of coefficient streams with polynomial framing.
// Latency: 2 cycles (input transfer at edge k -> out_valid at edge k+2), 1 beat/cycle sustained.
// Backpressure: 2-stage elastic pipeline; in_ready drops only when both stages are full and out_ready=0.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_sub/in_a/in_b input handshake;
//        out_valid/out_ready/out_data/out_last output handshake; err sticky range flag.
// Build option: define POLY_VEC_ADDSUB_RANGECHK_EN to build operand range checkers driving err;
//        otherwise err is tied to 0.
module poly_vec_addsub
  import poly_pkg::*;
#(
  parameter int unsigned Q     = Q_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned LOGQ  = LOGQ_DEF,
  parameter int unsigned LOGN  = LOGN_DEF,
  parameter int unsigned LANES = LANES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sub,
  input  logic [LANES*LOGQ-1:0] in_a,
  input  logic [LANES*LOGQ-1:0] in_b,
  output logic                  out_valid,
  output logic [LANES*LOGQ-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  err
);

  localparam int unsigned    BPP      = beats_per_poly(N, LANES);
  localparam logic [LOGN-1:0] LAST_CNT = LOGN'(BPP - 1);

  // Stage 1 registers
  logic                        r_s1_vld;
  logic                        r_s1_mode;
  logic                        r_s1_last;
  logic [LANES-1:0][LOGQ:0]    r_s1_raw;

  // Stage 2 (output) registers
  logic                        r_out_vld;
  logic [LANES*LOGQ-1:0]       r_out_data;
  logic                        r_out_last;

  logic [LOGN-1:0]             r_cnt;

  logic                        w_s2_load;
  logic                        w_s1_adv;
  logic                        w_in_xfer;
  logic                        w_last;
  logic [LANES-1:0][LOGQ:0]    w_raw;
  logic [LANES*LOGQ-1:0]       w_res;

  assign w_s2_load = !r_out_vld || out_ready;
  assign w_s1_adv  = w_s2_load || !r_s1_vld;
  // Depends only on state and out_ready, never on in_valid.
  assign in_ready  = !reset && w_s1_adv;
  assign w_in_xfer = in_valid && in_ready;
  assign w_last    = (r_cnt == LAST_CNT);

  assign out_valid = r_out_vld;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    poly_mod_lane #(
      .Q    (Q),
      .LOGQ (LOGQ)
    ) u_lane (
      .i_a    (in_a[g*LOGQ +: LOGQ]),
      .i_b    (in_b[g*LOGQ +: LOGQ]),
      .i_sub  (in_sub),
      .o_raw  (w_raw[g]),
      .i_raw  (r_s1_raw[g]),
      .i_mode (r_s1_mode),
      .o_res  (w_res[g*LOGQ +: LOGQ])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_mode  <= MODE_ADD;
      r_s1_last  <= 1'b0;
      r_s1_raw   <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_vld <= w_in_xfer;
        if (w_in_xfer) begin
          r_s1_raw  <= w_raw;
          r_s1_mode <= in_sub;
          r_s1_last <= w_last;
        end
      end
      // Output regs only change on a load that carries a beat, so data/last
      // hold steady while the consumer stalls.
      if (w_s2_load) begin
        r_out_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_out_data <= w_res;
          r_out_last <= r_s1_last;
        end
      end
      if (w_in_xfer) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

`ifdef POLY_VEC_ADDSUB_RANGECHK_EN
  localparam logic [LOGQ-1:0] QC = LOGQ'(Q);

  logic w_range_bad;
  logic r_err;

  always_comb begin
    w_range_bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if ((in_a[i*LOGQ +: LOGQ] >= QC) || (in_b[i*LOGQ +: LOGQ] >= QC)) begin
        w_range_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_in_xfer && w_range_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/poly_vec_addsub.md
Name: poly_vec_addsub

Overview:
- Multi-lane modular add/subtract unit for polynomial coefficient streams over Z_q.
- Each accepted beat carries LANES coefficient pairs. Every lane computes (a+b) mod Q or (a-b) mod Q, selected per beat.
- 2-stage elastic pipeline with valid/ready on both sides.
- Marks the last beat of each N-coefficient polynomial; sits between NTT/memory readers and downstream polynomial consumers.

Parameters:
- Q, 17, modulus; 2 <= Q < 2**LOGQ
- N, 8, coefficients per polynomial
- LOGQ, 5, coefficient width in bits
- LOGN, 3, log2(N)
- LANES, 2, coefficient pairs per beat; power of two, divides N

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  unit accepts beat this cycle
- in_sub  input  1  0 = add, 1 = subtract (a-b); applies to the whole beat
- in_a  input  LANES*LOGQ  operand A; lane i at bits [i*LOGQ +: LOGQ]
- in_b  input  LANES*LOGQ  operand B; same packing
- out_valid  output  1  output beat valid
- out_data  output  LANES*LOGQ  results; same packing
- out_last  output  1  beat is final beat of a polynomial
- out_ready  input  1  downstream accepts beat
- err  output  1  sticky range error (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high. While reset=1 at a rising edge:
  - all valid bits, out_data, out_last, err and the beat counter clear to 0
  - in_ready=0 during reset
- Reset mid-stream: in-flight beats are discarded and the next accepted beat is beat 0 of a new polynomial.
- Transfers: a transfer occurs on a side when valid && ready at a rising edge. in_ready must not depend on in_valid.
- Stage 1 (s1), for each lane:
  - add: raw = a+b, LOGQ+1 bits
  - sub: raw = a-b, or a-b+Q when a<b, LOGQ+1 bits
  - registers raw, the mode, and the last flag
- Stage 2 (s2):
  - add: out = raw>=Q ? raw-Q : raw
  - sub: out = raw, already in [0,Q)
  - out is truncated to LOGQ bits
- Stalling:
  - s2 loads when !out_valid || out_ready
  - s1 advances when s2 loads or s1 is empty
  - in_ready = !s1_valid || s2 loads
- Throughput and latency:
  - full throughput: 1 beat/cycle with out_ready held high
  - latency: input transfer at edge k gives out_valid at edge k+2 when not stalled
- Output holding: out_data and out_last stay stable while out_valid && !out_ready.
- Beat counter:
  - width LOGN bits, counts accepted input beats modulo N/LANES
  - last = (count == N/LANES-1); last travels with the beat to out_last
  - counter wraps to 0 after the last beat
  - in_sub may change on any beat without affecting counter or framing
- Operand contract: operands are assumed < Q. With the optional feature off, out-of-range operands give undefined but X-free results.
- Simultaneous events: an output transfer and an input transfer in the same cycle must both complete. No bubble is inserted and no beat is lost.

Optional Feature:
- Macro: POLY_VEC_ADDSUB_RANGECHK_EN
- Defined:
  - any lane with a >= Q or b >= Q on an input transfer sets err=1 at the next edge
  - err stays 1 until reset
  - the offending beat still flows through with an unspecified value
- Undefined: no comparators are built and err is tied to 0.

Decomposition:
- Package poly_pkg:
  - localparam helpers for beats-per-poly (N/LANES)
  - typedef coeff_t (logic [LOGQ-1:0])
  - mode encoding constants MODE_ADD=1'b0, MODE_SUB=1'b1
- Sub-module poly_mod_lane:
  - one lane's stage-1 raw compute plus stage-2 reduction function, parametrised by Q and LOGQ
  - instantiated LANES times via generate
  - pipeline control and beat counter stay in the top module

Test Plan:
All cases use Q=17, N=8, LANES=2 unless noted.
- Add with wrap: in_a={16,3}, in_b={5,4}, in_sub=0, out_ready=1 -> 2 cycles later out_data={4,7}, out_valid=1 for exactly one cycle.
- Subtract with borrow: in_a={2,10}, in_b={9,10}, in_sub=1 -> out_data={10,0}.
- Framing: 8 back-to-back beats -> out_last=1 on beats 4 and 8 only; 1 beat/cycle sustained, in_ready constantly 1.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 beats buffered; out_data stable while stalled; no beat lost or duplicated; order preserved vs. scoreboard.
- Reset mid-stream: assert reset after beat 2 of a polynomial -> out_valid=0 next edge; the next polynomial's out_last lands on its 4th beat.
- With POLY_VEC_ADDSUB_RANGECHK_EN: one beat with a=17 -> err=1 from the next edge and sticky until reset. Without the macro, err remains 0.
